// File: rtl/johnson_seq_ctrl.sv
// Run-length sequencer around a WIDTH-bit Johnson ring: forward/reverse runs,
// pause/resume, abort, preload, phase decode and a fault trap for illegal codes.
module johnson_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8,
  parameter int PH_W  = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] len,
  input  logic             pause,
  input  logic             abort,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [PH_W-1:0]  phase,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             err,
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;

  logic [WIDTH-1:0] q_fwd, q_rev, q_step;
  logic             q_legal, load_legal;

  // A Johnson code is legal exactly when it has at most one 0/1 boundary
  // between adjacent bits (a single contiguous run of ones at either end).
  function automatic logic is_legal(input logic [WIDTH-1:0] v);
    int t;
    t = 0;
    for (int i = 0; i < WIDTH-1; i++) begin
      t += int'(v[i] ^ v[i+1]);
    end
    return (t <= 1);
  endfunction

  assign q_fwd      = {~q_q[0], q_q[WIDTH-1:1]};
  assign q_rev      = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
  assign q_step     = dir_q ? q_rev : q_fwd;
  assign q_legal    = is_legal(q_q);
  assign load_legal = is_legal(load_val);

  always_comb begin
    state_d   = state_q;
    q_d       = q_q;
    rem_d     = rem_q;
    dir_d     = dir_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!q_legal) begin
          state_d = S_FAULT;
          q_d     = '0;
          rem_d   = '0;
        end else if (load) begin
          if (load_legal) begin
            q_d = load_val;
          end else begin
            state_d = S_FAULT;
            q_d     = '0;
            rem_d   = '0;
          end
        end else if (start) begin
          if (len != '0) begin
            state_d = S_RUN;
            dir_d   = dir;
            rem_d   = len;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d   = S_IDLE;
          q_d       = '0;
          rem_d     = '0;
          aborted_d = 1'b1;
        end else if (!q_legal) begin
          state_d = S_FAULT;
          q_d     = '0;
          rem_d   = '0;
        end else if (pause) begin
          state_d = S_HOLD;
        end else begin
          q_d   = q_step;
          rem_d = rem_q - 1'b1;
          if (rem_q == CNT_W'(1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (abort) begin
          state_d   = S_IDLE;
          q_d       = '0;
          rem_d     = '0;
          aborted_d = 1'b1;
        end else if (!q_legal) begin
          state_d = S_FAULT;
          q_d     = '0;
          rem_d   = '0;
        end else if (load) begin
          if (load_legal) begin
            q_d = load_val;
          end else begin
            state_d = S_FAULT;
            q_d     = '0;
            rem_d   = '0;
          end
        end else if (!pause) begin
          state_d = S_RUN;
        end
      end
      default: begin
        // FAULT holds the ring at zero until the host acknowledges with abort.
        q_d   = '0;
        rem_d = '0;
        if (abort) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      q_q       <= '0;
      rem_q     <= '0;
      dir_q     <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      rem_q     <= rem_d;
      dir_q     <= dir_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  // Phase index: ones filling from the top count up, ones draining from the
  // top count on from WIDTH towards 2*WIDTH-1.
  always_comb begin
    int pop;
    pop = 0;
    for (int i = 0; i < WIDTH; i++) begin
      pop += int'(q_q[i]);
    end
    if (q_q == '0 || q_q[WIDTH-1]) begin
      phase = PH_W'(pop);
    end else begin
      phase = PH_W'(2*WIDTH - pop);
    end
  end

  assign q         = q_q;
  assign busy      = (state_q == S_RUN) || (state_q == S_HOLD);
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign err       = (state_q == S_FAULT);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Bench for johnson_seq_ctrl: vector table, directed corner sequences and a
// randomized run, all checked against a phase-arithmetic reference model.
module tb_johnson_seq_ctrl;
  localparam int W  = 4;
  localparam int CW = 8;
  localparam int NP = 2*W;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, dir, pause, abort, load;
  logic [CW-1:0] len;
  logic [W-1:0]  load_val;
  logic [W-1:0]  q;
  logic [2:0]    phase;
  logic          busy, done, aborted, err;
  logic [1:0]    dbg_state;

  johnson_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .len(len),
    .pause(pause), .abort(abort), .load(load), .load_val(load_val),
    .q(q), .phase(phase), .busy(busy), .done(done), .aborted(aborted),
    .err(err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: ring tracked as a phase number, mode 0=idle 1=run 2=hold 3=fault.
  int m_mode, m_p, m_rem, m_dir;
  bit m_done, m_ab;

  function automatic logic [W-1:0] q_of(input int p);
    int v;
    if (p <= W) v = ((1 << p) - 1) << (W - p);
    else        v = (1 << (NP - p)) - 1;
    return v[W-1:0];
  endfunction

  function automatic int phase_of(input logic [W-1:0] v);
    for (int p = 0; p < NP; p++) if (q_of(p) == v) return p;
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_p = 0; m_rem = 0; m_dir = 0; m_done = 0; m_ab = 0;
  endtask

  task automatic model_step();
    int lp;
    m_done = 0; m_ab = 0;
    lp = phase_of(load_val);
    case (m_mode)
      0: begin
        if (load) begin
          if (lp >= 0) m_p = lp;
          else begin m_mode = 3; m_p = 0; end
        end else if (start) begin
          if (len != 0) begin m_mode = 1; m_dir = int'(dir); m_rem = int'(len); end
          else m_done = 1;
        end
      end
      1: begin
        if (abort) begin m_mode = 0; m_p = 0; m_ab = 1; end
        else if (pause) m_mode = 2;
        else begin
          m_p = m_dir ? (m_p + NP - 1) % NP : (m_p + 1) % NP;
          m_rem--;
          if (m_rem == 0) begin m_mode = 0; m_done = 1; end
        end
      end
      2: begin
        if (abort) begin m_mode = 0; m_p = 0; m_ab = 1; end
        else if (load) begin
          if (lp >= 0) m_p = lp;
          else begin m_mode = 3; m_p = 0; end
        end else if (!pause) m_mode = 1;
      end
      default: if (abort) m_mode = 0;
    endcase
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // One clock: advance the model with the current inputs, then compare after the edge.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("q", int'(q), int'(q_of(m_p)));
    check("phase", int'(phase), m_p);
    check("busy", int'(busy), int'(m_mode == 1 || m_mode == 2));
    check("done", int'(done), int'(m_done));
    check("aborted", int'(aborted), int'(m_ab));
    check("err", int'(err), int'(m_mode == 3));
  endtask

  task automatic idle_inputs();
    start = 0; dir = 0; len = '0; pause = 0; abort = 0; load = 0; load_val = '0;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    idle_inputs(); load = 1; load_val = v; cycle(); idle_inputs();
  endtask

  task automatic do_start(input logic d, input logic [CW-1:0] n);
    idle_inputs(); start = 1; dir = d; len = n; cycle(); idle_inputs();
  endtask

  typedef struct {
    logic          start;
    logic          dir;
    logic [CW-1:0] len;
    logic          load;
    logic [W-1:0]  load_val;
    logic [W-1:0]  exp_q;
    logic [2:0]    exp_phase;
    logic          exp_busy;
    logic          exp_done;
  } vec_t;

  vec_t vecs[$];

  initial begin
    bit got;
    rst = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_q", int'(q), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_aborted", int'(aborted), 0);
    check("rst_err", int'(err), 0);
    @(negedge clk);
    rst = 1'b0;

    // Forward run of 8 from zero, then preload 0011 and reverse run of 3.
    vecs.push_back('{1, 0, 8, 0, 4'b0000, 4'b0000, 0, 1, 0});
    vecs.push_back('{0, 0, 0, 0, 4'b0000, 4'b1000, 1, 1, 0});
    vecs.push_back('{0, 0, 0, 0, 4'b0000, 4'b1100, 2, 1, 0});
    vecs.push_back('{0, 0, 0, 0, 4'b0000, 4'b1110, 3, 1, 0});
    vecs.push_back('{0, 0, 0, 0, 4'b0000, 4'b1111, 4, 1, 0});
    vecs.push_back('{0, 0, 0, 0, 4'b0000, 4'b0111, 5, 1, 0});
    vecs.push_back('{0, 0, 0, 0, 4'b0000, 4'b0011, 6, 1, 0});
    vecs.push_back('{0, 0, 0, 0, 4'b0000, 4'b0001, 7, 1, 0});
    vecs.push_back('{0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 1});
    vecs.push_back('{0, 0, 0, 1, 4'b0011, 4'b0011, 6, 0, 0});
    vecs.push_back('{1, 1, 3, 0, 4'b0000, 4'b0011, 6, 1, 0});
    vecs.push_back('{0, 0, 0, 0, 4'b0000, 4'b0111, 5, 1, 0});
    vecs.push_back('{0, 0, 0, 0, 4'b0000, 4'b1111, 4, 1, 0});
    vecs.push_back('{0, 0, 0, 0, 4'b0000, 4'b1110, 3, 0, 1});
    vecs.push_back('{0, 0, 0, 0, 4'b0000, 4'b1110, 3, 0, 0});
    for (int i = 0; i < vecs.size(); i++) begin
      idle_inputs();
      start = vecs[i].start; dir = vecs[i].dir; len = vecs[i].len;
      load = vecs[i].load; load_val = vecs[i].load_val;
      cycle();
      check($sformatf("vec%0d_q", i), int'(q), int'(vecs[i].exp_q));
      check($sformatf("vec%0d_phase", i), int'(phase), int'(vecs[i].exp_phase));
      check($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].exp_busy));
      check($sformatf("vec%0d_done", i), int'(done), int'(vecs[i].exp_done));
    end
    idle_inputs();

    // Pause after step 2 for three cycles: ring frozen at 1100.
    do_load(4'b0000);
    do_start(0, 5);
    cycle(); cycle();
    pause = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("hold_q", int'(q), int'(4'b1100));
      check("hold_busy", int'(busy), 1);
    end
    pause = 0;
    got = 0;
    for (int i = 0; i < 12 && !got; i++) begin
      cycle();
      got = done;
    end
    check("pause_done_seen", int'(got), 1);
    check("pause_end_q", int'(q), int'(4'b0111));

    // Abort after step 4.
    do_load(4'b0000);
    do_start(0, 8);
    repeat (4) cycle();
    check("pre_abort_q", int'(q), int'(4'b1111));
    abort = 1; cycle(); abort = 0;
    check("abort_q", int'(q), 0);
    check("abort_pulse", int'(aborted), 1);
    check("abort_done", int'(done), 0);
    check("abort_busy", int'(busy), 0);
    cycle();

    // Illegal preload traps into FAULT; start ignored; abort clears.
    do_load(4'b0101);
    check("fault_err", int'(err), 1);
    check("fault_q", int'(q), 0);
    do_start(0, 4);
    check("fault_start_busy", int'(busy), 0);
    check("fault_start_err", int'(err), 1);
    abort = 1; cycle(); abort = 0;
    check("fault_clear_err", int'(err), 0);

    // Zero-length start: done pulse only, ring untouched.
    do_load(4'b0111);
    do_start(1, 0);
    check("len0_done", int'(done), 1);
    check("len0_busy", int'(busy), 0);
    check("len0_q", int'(q), int'(4'b0111));
    cycle();

    // Reset in the middle of a long run.
    do_load(4'b0000);
    do_start(0, 200);
    repeat (10) cycle();
    #2 rst = 1'b1;
    #1;
    check("midrst_q", int'(q), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_err", int'(err), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle();

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      start    = ($urandom_range(0, 3) == 0);
      dir      = 1'($urandom_range(0, 1));
      len      = CW'($urandom_range(0, 12));
      pause    = ($urandom_range(0, 4) == 0);
      abort    = ($urandom_range(0, 19) == 0);
      load     = ($urandom_range(0, 9) == 0);
      load_val = W'($urandom_range(0, 15));
      cycle();
    end
    idle_inputs();
    abort = 1; cycle(); abort = 0;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
